// File: rtl/lbist_pkg.sv
// Shared definitions for the logic BIST blocks: FSM states, counter width
// and default feedback tap masks for the supported register widths.
package lbist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lbist_state_e;

    localparam int CNT_W = 16;

    // Bit i set means s[i] feeds back.
    localparam logic [6:0]  TAPS_7  = 7'h44;
    localparam logic [18:0] TAPS_19 = 19'h40013;
    localparam logic [19:0] TAPS_20 = 20'h80004;

endpackage

// File: rtl/lbist_misr_core.sv
// Signature register with multiple-input compaction; the FSM around it
// decides when to load the seed and when to take a compaction step.
module lbist_misr_core
    import lbist_pkg::*;
#(
    parameter int              N    = 20,
    parameter logic [N-1:0]    TAPS = TAPS_20,
    parameter logic [N-1:0]    SEED = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] seed,
    input  logic         step,
    input  logic [N-1:0] d,
    output logic [N-1:0] sig,
    output logic [N-1:0] sig_next
);

    logic fb;

    always_comb begin
        fb       = ^(sig & TAPS);
        sig_next = {sig[N-2:0], fb} ^ d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (load) begin
            sig <= seed;
        end else if (step) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/lbist_misr.sv
// Logic BIST MISR stage: compacts NPAT response words and checks the result
// against GOLDEN. Define LBIST_MISR_XMASK_EN to add the xmask input.
module lbist_misr
    import lbist_pkg::*;
#(
    parameter int              N      = 20,
    parameter logic [N-1:0]    TAPS   = TAPS_20,
    parameter logic [N-1:0]    SEED   = '0,
    parameter int unsigned     NPAT   = 1000,
    parameter logic [N-1:0]    GOLDEN = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         en,
    input  logic [N-1:0] resp,
`ifdef LBIST_MISR_XMASK_EN
    input  logic [N-1:0] xmask,
`endif
    output logic [N-1:0] signature,
    output logic         busy,
    output logic         done,
    output logic         pass
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NPAT - 1);

    lbist_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     d;
    logic [N-1:0]     sig_next;
    logic             load;
    logic             step;

`ifdef LBIST_MISR_XMASK_EN
    assign d = resp & ~xmask;
`else
    assign d = resp;
`endif

    // start wins over en outside RUN, so a coincident en never compacts.
    assign load = (state != RUN) && start;
    assign step = (state == RUN) && en;

    lbist_misr_core #(
        .N    (N),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .seed     (SEED),
        .step     (step),
        .d        (d),
        .sig      (signature),
        .sig_next (sig_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (en) begin
                        cnt <= cnt + 16'd1;
                        // Last word: the compare uses the value being written this edge.
                        if (cnt == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (sig_next == GOLDEN);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbist_misr.sv
// Self-checking bench for lbist_misr: four instances with different NPAT,
// SEED and GOLDEN share one stimulus stream and are compared to a run model.
module tb_lbist_misr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        en = 1'b0;
    logic [19:0] resp = '0;
`ifdef LBIST_MISR_XMASK_EN
    logic [19:0] xmask_v = '0;
`endif

    logic [3:0][19:0] sig_o;
    logic [3:0]       busy_o;
    logic [3:0]       done_o;
    logic [3:0]       pass_o;

    int checks = 0;
    int failures = 0;

    // Instance parameters, mirrored for the model.
    int          np    [4] = '{2, 2, 4, 9};
    logic [19:0] gold  [4] = '{20'h00002, 20'h00003, 20'h00000, 20'h12345};
    logic [19:0] seedv [4] = '{20'h00000, 20'h00000, 20'h00000, 20'h5A5A5};

    // Model state per instance: phase 0 = idle, 1 = running, 2 = finished.
    int          m_phase [4];
    int          m_cnt   [4];
    logic [19:0] m_sig   [4];
    bit          m_pass  [4];

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 4; g++) begin : g_dut
        localparam int          GNP   = (g == 0) ? 2 : (g == 1) ? 2 : (g == 2) ? 4 : 9;
        localparam logic [19:0] GGOLD = (g == 0) ? 20'h00002 : (g == 1) ? 20'h00003 :
                                        (g == 2) ? 20'h00000 : 20'h12345;
        localparam logic [19:0] GSEED = (g == 3) ? 20'h5A5A5 : 20'h00000;
        lbist_misr #(
            .N      (20),
            .TAPS   (20'h80004),
            .SEED   (GSEED),
            .NPAT   (GNP),
            .GOLDEN (GGOLD)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .en        (en),
            .resp      (resp),
`ifdef LBIST_MISR_XMASK_EN
            .xmask     (xmask_v),
`endif
            .signature (sig_o[g]),
            .busy      (busy_o[g]),
            .done      (done_o[g]),
            .pass      (pass_o[g])
        );
    end

    // Polynomial x^20 + x^3 + 1: shift up, feed s[19]^s[2] into bit 0, add the word.
    function automatic logic [19:0] misr_f(input logic [19:0] s, input logic [19:0] d);
        logic [19:0] t;
        t = s << 1;
        t[0] = s[19] ^ s[2];
        return t ^ d;
    endfunction

    function automatic logic [22:0] exp_v(input int i);
        return {m_sig[i], m_phase[i] == 1, m_phase[i] == 2, m_pass[i]};
    endfunction

    function automatic logic [22:0] obs_v(input int i);
        return {sig_o[i], busy_o[i], done_o[i], pass_o[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_phase[i] = 0;
            m_cnt[i]   = 0;
            m_sig[i]   = seedv[i];
            m_pass[i]  = 1'b0;
        end
    endtask

    task automatic model_edge(input bit s, input bit e, input logic [19:0] d);
        for (int i = 0; i < 4; i++) begin
            if (m_phase[i] == 1) begin
                if (e) begin
                    m_sig[i] = misr_f(m_sig[i], d);
                    m_cnt[i]++;
                    if (m_cnt[i] == np[i]) begin
                        m_phase[i] = 2;
                        m_pass[i]  = (m_sig[i] == gold[i]);
                    end
                end
            end else if (s) begin
                m_sig[i]   = seedv[i];
                m_cnt[i]   = 0;
                m_pass[i]  = 1'b0;
                m_phase[i] = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
    task automatic step(input bit s, input bit e, input logic [19:0] r, input logic [19:0] x);
        start = s;
        en    = e;
        resp  = r;
`ifdef LBIST_MISR_XMASK_EN
        xmask_v = x;
`endif
        @(posedge clk);
        model_edge(s, e, r & ~x);
        #1;
        start = 1'b0;
        en    = 1'b0;
    endtask

    function automatic logic [19:0] rand_mask();
`ifdef LBIST_MISR_XMASK_EN
        return 20'($urandom);
`else
        return 20'h0;
`endif
    endfunction

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_v(i) !== {seedv[i], 3'b000}) begin
                failures++;
                $display("FAIL reset inst%0d got=%h exp=%h", i, obs_v(i), {seedv[i], 3'b000});
            end
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_zero_resp();
        step(1'b1, 1'b0, 20'h0, 20'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 20'h0, 20'h0);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_v(i) !== exp_v(i)) begin
                    failures++;
                    $display("FAIL zero_resp inst%0d step%0d got=%h exp=%h", i, k, obs_v(i), exp_v(i));
                end
            end
        end
        checks++;
        if ({sig_o[2], busy_o[2], done_o[2], pass_o[2]} !== {20'h00000, 3'b011}) begin
            failures++;
            $display("FAIL zero_resp_final got=%h exp=%h", obs_v(2), {20'h00000, 3'b011});
        end
    endtask

    task automatic test_golden();
        step(1'b1, 1'b0, 20'h0, 20'h0);
        step(1'b0, 1'b1, 20'h00001, 20'h0);
        step(1'b0, 1'b1, 20'h00000, 20'h0);
        checks++;
        if ({sig_o[0], done_o[0], pass_o[0]} !== {20'h00002, 2'b11}) begin
            failures++;
            $display("FAIL golden_match got=%h exp=%h", {sig_o[0], done_o[0], pass_o[0]}, {20'h00002, 2'b11});
        end
        checks++;
        if ({sig_o[1], done_o[1], pass_o[1]} !== {20'h00002, 2'b10}) begin
            failures++;
            $display("FAIL golden_miss got=%h exp=%h", {sig_o[1], done_o[1], pass_o[1]}, {20'h00002, 2'b10});
        end
    endtask

    task automatic test_feedback();
        step(1'b1, 1'b0, 20'h0, 20'h0);
        step(1'b0, 1'b1, 20'h80000, 20'h0);
        step(1'b0, 1'b1, 20'h00000, 20'h0);
        checks++;
        if ({sig_o[0], done_o[0], pass_o[0]} !== {20'h00001, 2'b10}) begin
            failures++;
            $display("FAIL feedback got=%h exp=%h", {sig_o[0], done_o[0], pass_o[0]}, {20'h00001, 2'b10});
        end
    endtask

    task automatic test_start_with_en();
        // Instance 0 is in DONE here; start+en must only reload the seed.
        step(1'b1, 1'b1, 20'hFFFFF, 20'h0);
        checks++;
        if ({sig_o[0], busy_o[0], done_o[0]} !== {20'h00000, 2'b10}) begin
            failures++;
            $display("FAIL start_en got=%h exp=%h", {sig_o[0], busy_o[0], done_o[0]}, {20'h00000, 2'b10});
        end
        step(1'b0, 1'b1, 20'h00001, 20'h0);
        checks++;
        if (sig_o[0] !== 20'h00001) begin
            failures++;
            $display("FAIL start_en_first got=%h exp=%h", sig_o[0], 20'h00001);
        end
    endtask

    task automatic test_gaps_random();
        for (int run = 0; run < 4; run++) begin
            step(1'b1, 1'b0, 20'h0, 20'h0);
            for (int k = 0; k < 40; k++) begin
                step(($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1), 20'($urandom), rand_mask());
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (obs_v(i) !== exp_v(i)) begin
                        failures++;
                        $display("FAIL gaps run%0d cyc%0d inst%0d got=%h exp=%h", run, k, i, obs_v(i), exp_v(i));
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 20'h0, 20'h0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 20'($urandom), 20'h0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_v(i) !== {seedv[i], 3'b000}) begin
                failures++;
                $display("FAIL async_reset inst%0d got=%h exp=%h", i, obs_v(i), {seedv[i], 3'b000});
            end
        end
        #2 rst_n = 1'b1;
        step(1'b1, 1'b0, 20'h0, 20'h0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 20'($urandom), 20'h0);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_v(i) !== exp_v(i)) begin
                    failures++;
                    $display("FAIL post_reset inst%0d step%0d got=%h exp=%h", i, k, obs_v(i), exp_v(i));
                end
            end
        end
        checks++;
        if ({busy_o[3], done_o[3]} !== 2'b01) begin
            failures++;
            $display("FAIL post_reset_len got=%b exp=01", {busy_o[3], done_o[3]});
        end
    endtask

`ifdef LBIST_MISR_XMASK_EN
    task automatic test_xmask();
        step(1'b1, 1'b0, 20'h0, 20'h0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 20'hFFFFF, 20'hFFFFF);
        checks++;
        if ({sig_o[2], done_o[2], pass_o[2]} !== {20'h00000, 2'b11}) begin
            failures++;
            $display("FAIL xmask got=%h exp=%h", {sig_o[2], done_o[2], pass_o[2]}, {20'h00000, 2'b11});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_resp();
        test_golden();
        test_feedback();
        test_start_with_en();
        test_gaps_random();
        test_async_reset();
`ifdef LBIST_MISR_XMASK_EN
        test_xmask();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
